// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the pd5 pipeline: base opcodes, the canonical NOP
// and per-opcode register-usage helpers.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h00000013;

  // Unknown opcodes are treated as reading rs1 so a hazard is never missed.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic used;
    case (opcode)
      LUI, AUIPC, JAL: used = 1'b0;
      default:         used = 1'b1;
    endcase
    return used;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic used;
    case (opcode)
      BRANCH, STORE, OP: used = 1'b1;
      default:           used = 1'b0;
    endcase
    return used;
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    logic used;
    case (opcode)
      BRANCH, STORE: used = 1'b0;
      default:       used = 1'b1;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/decode_operand_stage_imm_gen.sv
// Combinational RV32 immediate generator; also reused by the PC-target logic,
// so it stays free of any pipeline state.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] imm
);

  logic sign_s;

  assign sign_s = insn[31];

  // Select the immediate layout from the opcode; unknown opcodes give zero.
  always_comb begin
    imm = 32'h00000000;
    case (insn[6:0])
      OP_IMM, LOAD, JALR: imm = {{20{sign_s}}, insn[31:20]};
      STORE:              imm = {{20{sign_s}}, insn[31:25], insn[11:7]};
      BRANCH:             imm = {{19{sign_s}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      LUI, AUIPC:         imm = {insn[31:12], 12'h000};
      JAL:                imm = {{11{sign_s}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default:            imm = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/decode_operand_stage.sv
// pd5 ID stage: register-file addressing, writeback bypass, immediate decode,
// load-use stall and the ID/EX pipeline register.
module decode_operand_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSN
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_insn,
  output logic [4:0]  rf_addr_rs1,
  output logic [4:0]  rf_addr_rs2,
  input  logic [31:0] rf_data_rs1,
  input  logic [31:0] rf_data_rs2,
  input  logic        wb_write_enable,
  input  logic [4:0]  wb_addr_rd,
  input  logic [31:0] wb_data_rd,
  input  logic        ex_flush,
  output logic        stall_if,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_insn,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic        ex_is_load
);

  logic [6:0]      opcode_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;
  logic            hz_s;

  assign opcode_s    = if_insn[6:0];
  assign rs1_s       = if_insn[19:15];
  assign rs2_s       = if_insn[24:20];
  assign rf_addr_rs1 = rs1_s;
  assign rf_addr_rs2 = rs2_s;

  imm_gen u_imm_gen (
    .insn (if_insn),
    .imm  (imm_s)
  );

  // Destination index, zeroed for opcodes that write no register.
  always_comb begin
    rd_s = 5'd0;
    if (writes_rd(opcode_s)) begin
      rd_s = if_insn[11:7];
    end else begin
      rd_s = 5'd0;
    end
  end

  // The register file writes on the edge, so forward the in-flight writeback.
  always_comb begin
    rs1_data_s = rf_data_rs1;
    rs2_data_s = rf_data_rs2;
    if (wb_write_enable && (wb_addr_rd != 5'd0) && (wb_addr_rd == rs1_s)) begin
      rs1_data_s = wb_data_rd;
    end else begin
      rs1_data_s = rf_data_rs1;
    end
    if (wb_write_enable && (wb_addr_rd != 5'd0) && (wb_addr_rd == rs2_s)) begin
      rs2_data_s = wb_data_rd;
    end else begin
      rs2_data_s = rf_data_rs2;
    end
  end

  // Load-use: the load in EX has no data yet for a dependent instruction in ID.
  always_comb begin
    hz_s = 1'b0;
    if (if_valid && ex_valid && ex_is_load && (ex_rd != 5'd0)) begin
      hz_s = (uses_rs1(opcode_s) && (rs1_s == ex_rd)) ||
             (uses_rs2(opcode_s) && (rs2_s == ex_rd));
    end else begin
      hz_s = 1'b0;
    end
  end

  // A flush discards the stalled instruction, so it also cancels the stall.
  always_comb begin
    stall_if = 1'b0;
    if (reset || ex_flush) begin
      stall_if = 1'b0;
    end else begin
      stall_if = hz_s;
    end
  end

  // ID/EX pipeline register: reset, then flush/stall bubbles, else capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'h00000000;
      ex_insn     <= NOP;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_rs1_data <= 32'h00000000;
      ex_rs2_data <= 32'h00000000;
      ex_imm      <= 32'h00000000;
      ex_is_load  <= 1'b0;
    end else if (ex_flush || hz_s) begin
      ex_valid   <= 1'b0;
      ex_insn    <= NOP;
      ex_rd      <= 5'd0;
      ex_is_load <= 1'b0;
    end else begin
      ex_valid    <= if_valid;
      ex_pc       <= if_pc;
      ex_insn     <= if_insn;
      ex_rs1      <= rs1_s;
      ex_rs2      <= rs2_s;
      ex_rd       <= rd_s;
      ex_rs1_data <= rs1_data_s;
      ex_rs2_data <= rs2_data_s;
      ex_imm      <= imm_s;
      ex_is_load  <= (opcode_s == LOAD);
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for the pd5 ID stage: reset, bypass, load-use stall, flush
// priority and immediate decode, each against hand-computed values.
module tb_decode_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic [4:0]  rf_addr_rs1;
  logic [4:0]  rf_addr_rs2;
  logic [31:0] rf_data_rs1;
  logic [31:0] rf_data_rs2;
  logic        wb_write_enable;
  logic [4:0]  wb_addr_rd;
  logic [31:0] wb_data_rd;
  logic        ex_flush;
  logic        stall_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_insn;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic        ex_is_load;

  int passed = 0;
  int total  = 0;

  decode_operand_stage dut (
    .clock           (clock),
    .reset           (reset),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_insn         (if_insn),
    .rf_addr_rs1     (rf_addr_rs1),
    .rf_addr_rs2     (rf_addr_rs2),
    .rf_data_rs1     (rf_data_rs1),
    .rf_data_rs2     (rf_data_rs2),
    .wb_write_enable (wb_write_enable),
    .wb_addr_rd      (wb_addr_rd),
    .wb_data_rd      (wb_data_rd),
    .ex_flush        (ex_flush),
    .stall_if        (stall_if),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_insn         (ex_insn),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_rs1_data     (ex_rs1_data),
    .ex_rs2_data     (ex_rs2_data),
    .ex_imm          (ex_imm),
    .ex_is_load      (ex_is_load)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Advance one clock and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] insn);
    if_valid = 1'b1;
    if_pc    = pc;
    if_insn  = insn;
    #1;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = 32'h0; if_insn = 32'h0;
    rf_data_rs1 = 32'h0; rf_data_rs2 = 32'h0;
    wb_write_enable = 1'b0; wb_addr_rd = 5'd0; wb_data_rd = 32'h0; ex_flush = 1'b0;
    tick(); tick();

    // 1. reset state, then addi x5,x0,7
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_insn", ex_insn, 32'h00000013);
    check("rst_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_stall", {31'd0, stall_if}, 32'd0);
    reset = 1'b0;
    present(32'h100, 32'h00700293);
    tick();
    check("addi_rd", {27'd0, ex_rd}, 32'd5);
    check("addi_imm", ex_imm, 32'd7);
    check("addi_valid", {31'd0, ex_valid}, 32'd1);
    check("addi_pc", ex_pc, 32'h100);

    // 2. bypass of add x4,x3,x3
    present(32'h104, 32'h00318233);
    rf_data_rs1 = 32'h10; rf_data_rs2 = 32'h10;
    wb_write_enable = 1'b1; wb_addr_rd = 5'd3; wb_data_rd = 32'h55;
    #1;
    check("rf_addr_rs1", {27'd0, rf_addr_rs1}, 32'd3);
    tick();
    check("byp_rs1", ex_rs1_data, 32'h55);
    check("byp_rs2", ex_rs2_data, 32'h55);
    wb_addr_rd = 5'd0;
    tick();
    check("nobyp_x0_rs1", ex_rs1_data, 32'h10);
    check("nobyp_x0_rs2", ex_rs2_data, 32'h10);
    wb_write_enable = 1'b0; wb_addr_rd = 5'd3;
    tick();
    check("nobyp_we0", ex_rs1_data, 32'h10);

    // 3. load-use: lw x6,0(x1); add x7,x6,x2
    present(32'h200, 32'h0000A303);
    tick();
    check("lw_is_load", {31'd0, ex_is_load}, 32'd1);
    present(32'h204, 32'h002303B3);
    check("lu_stall", {31'd0, stall_if}, 32'd1);
    check("lu_addr_rs2", {27'd0, rf_addr_rs2}, 32'd2);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_insn", ex_insn, 32'h00000013);
    check("lu_stall_clear", {31'd0, stall_if}, 32'd0);
    tick();
    check("lu_add_rs1", {27'd0, ex_rs1}, 32'd6);
    check("lu_add_rd", {27'd0, ex_rd}, 32'd7);
    check("lu_add_valid", {31'd0, ex_valid}, 32'd1);

    // 4. no false stalls
    present(32'h300, 32'h0000A303);
    tick();
    present(32'h304, 32'h00030337);
    check("lui_nostall", {31'd0, stall_if}, 32'd0);
    tick();
    check("lui_imm", ex_imm, 32'h00030000);
    present(32'h308, 32'h0000A303);
    tick();
    present(32'h30C, 32'h00608393);
    check("opimm_rs2_nostall", {31'd0, stall_if}, 32'd0);
    tick();
    present(32'h310, 32'h0000A003);
    tick();
    check("lw_x0_rd", {27'd0, ex_rd}, 32'd0);
    present(32'h314, 32'h000003B3);
    check("x0_nostall", {31'd0, stall_if}, 32'd0);
    tick();

    // 5. flush beats a load-use hazard
    present(32'h400, 32'h0000A303);
    tick();
    present(32'h404, 32'h002303B3);
    ex_flush = 1'b1;
    #1;
    check("fl_stall", {31'd0, stall_if}, 32'd0);
    tick();
    ex_flush = 1'b0;
    check("fl_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_insn", ex_insn, 32'h00000013);

    // reset overrides a pending stall
    present(32'h500, 32'h0000A303);
    tick();
    present(32'h504, 32'h002303B3);
    reset = 1'b1;
    #1;
    check("rst_mid_stall", {31'd0, stall_if}, 32'd0);
    tick();
    check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    reset = 1'b0;

    // 6. immediates
    present(32'h600, 32'hFE000EE3);
    tick();
    check("beq_imm", ex_imm, 32'hFFFFFFFC);
    check("beq_rd", {27'd0, ex_rd}, 32'd0);
    present(32'h604, 32'h001000EF);
    tick();
    check("jal_imm", ex_imm, 32'h00000800);
    check("jal_rd", {27'd0, ex_rd}, 32'd1);
    present(32'h608, 32'hFE000FA3);
    tick();
    check("sw_imm", ex_imm, 32'hFFFFFFFF);
    check("sw_rd", {27'd0, ex_rd}, 32'd0);

    // if_valid low captures an invalid entry
    if_valid = 1'b0;
    tick();
    check("invalid_capture", {31'd0, ex_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
